// File: rtl/mem_pkg.sv
// Shared helpers for the block memory arbiter.
//   wrap_idx : element index (addr + ofs) mod depth, depth a power of two
//   id_width : width of a channel id for n channels, at least 1 bit
package mem_pkg;

  function automatic int unsigned wrap_idx(input logic [31:0] addr,
                                           input int unsigned ofs,
                                           input int unsigned depth);
    logic [31:0] sum;
    sum = addr + ofs;
    return sum & (depth - 1);
  endfunction

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/blk_mem_arb_if.sv
// Bus bundle for blk_mem_arb: one write port, NUM_RD read request channels,
// one shared read response port.
//   slave  : the memory/arbiter side
//   master : the requester/consumer side
interface blk_mem_arb_if
  import mem_pkg::*;
#(
  parameter int SIZE       = 32,
  parameter int BLOCK_SIZE = 5,
  parameter int ADDR_SIZE  = 24,
  parameter int NUM_RD     = 2
);
  localparam int WS_W = $clog2(BLOCK_SIZE + 1);
  localparam int ID_W = id_width(NUM_RD);

  logic                           i_wr_valid;
  logic                           o_wr_ready;
  logic [ADDR_SIZE-1:0]           i_wr_addr;
  logic [SIZE*BLOCK_SIZE-1:0]     i_wr_data;
  logic [WS_W-1:0]                i_wr_size;
  logic [NUM_RD-1:0]              i_rd_valid;
  logic [NUM_RD-1:0]              o_rd_ready;
  logic [NUM_RD*ADDR_SIZE-1:0]    i_rd_addr;
  logic                           o_rsp_valid;
  logic                           i_rsp_ready;
  logic [SIZE*BLOCK_SIZE-1:0]     o_rsp_data;
  logic [ID_W-1:0]                o_rsp_id;

  modport slave (
    input  i_wr_valid, i_wr_addr, i_wr_data, i_wr_size,
    input  i_rd_valid, i_rd_addr, i_rsp_ready,
    output o_wr_ready, o_rd_ready, o_rsp_valid, o_rsp_data, o_rsp_id
  );

  modport master (
    output i_wr_valid, i_wr_addr, i_wr_data, i_wr_size,
    output i_rd_valid, i_rd_addr, i_rsp_ready,
    input  o_wr_ready, o_rd_ready, o_rsp_valid, o_rsp_data, o_rsp_id
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter, one grant per cycle.
//   i_clk, i_rst : clock, synchronous active-high reset (pointer -> 0)
//   req          : per-channel requests
//   en           : grant permitted this cycle
//   gnt          : one-hot grant (all zero when en=0 or no request)
// The pointer names the highest-priority channel; it moves to the channel
// after the winner, and only when a grant is actually issued.
module rr_arbiter
  import mem_pkg::*;
#(
  parameter int N = 2
)(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);
  localparam int PW = id_width(N);

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  int            best_d;
  int            best_c;
  int            d;

  // Winner is the requesting channel with the smallest distance from ptr.
  always_comb begin
    best_d  = N;
    best_c  = 0;
    d       = 0;
    gnt     = '0;
    ptr_nxt = ptr;
    for (int c = 0; c < N; c++) begin
      d = (c + N - int'(ptr)) % N;
      if (en && req[c] && d < best_d) begin
        best_d = d;
        best_c = c;
      end
    end
    for (int c = 0; c < N; c++) begin
      gnt[c] = (best_d < N) && (c == best_c);
    end
    if (best_d < N) begin
      ptr_nxt = PW'((best_c + 1) % N);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr <= '0;
    end else if (|gnt) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/blk_mem_arb.sv
// Block-transfer memory with one write port and NUM_RD arbitrated read
// channels sharing a single registered response slot.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus          : blk_mem_arb_if.slave (write, read requests, response)
// Writes are never stalled. Reads are granted round-robin, one per cycle,
// only when the response slot is free or being drained; data appears one
// cycle after the grant. Memory contents survive reset.
module blk_mem_arb
  import mem_pkg::*;
#(
  parameter int DEPTH      = 1024,
  parameter int SIZE       = 32,
  parameter int BLOCK_SIZE = 5,
  parameter int ADDR_SIZE  = 24,
  parameter int NUM_RD     = 2
)(
  input  logic         i_clk,
  input  logic         i_rst,
  blk_mem_arb_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int ID_W  = id_width(NUM_RD);

  logic [SIZE-1:0]            mem [DEPTH];
  logic [NUM_RD-1:0]          gnt;
  logic                       arb_en;
  logic [ADDR_SIZE-1:0]       rd_addr;
  logic [ID_W-1:0]            gnt_id;
  logic                       rsp_valid;
  logic [SIZE*BLOCK_SIZE-1:0] rsp_data;
  logic [ID_W-1:0]            rsp_id;

  assign bus.o_wr_ready  = ~i_rst;
  assign bus.o_rd_ready  = gnt;
  assign bus.o_rsp_valid = rsp_valid;
  assign bus.o_rsp_data  = rsp_data;
  assign bus.o_rsp_id    = rsp_id;

  assign arb_en = ~i_rst & (~rsp_valid | bus.i_rsp_ready);

  rr_arbiter #(.N(NUM_RD)) u_arb (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .req   (bus.i_rd_valid),
    .en    (arb_en),
    .gnt   (gnt)
  );

  always_comb begin
    rd_addr = '0;
    gnt_id  = '0;
    for (int c = 0; c < NUM_RD; c++) begin
      if (gnt[c]) begin
        rd_addr = bus.i_rd_addr[c*ADDR_SIZE +: ADDR_SIZE];
        gnt_id  = ID_W'(c);
      end
    end
  end

  // The loop stops at BLOCK_SIZE, so oversize requests clamp naturally.
  always_ff @(posedge i_clk) begin
    if (bus.i_wr_valid && bus.o_wr_ready) begin
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        if (i < int'(bus.i_wr_size)) begin
          mem[IDX_W'(wrap_idx(32'(bus.i_wr_addr), i, DEPTH))] <=
            bus.i_wr_data[SIZE*(BLOCK_SIZE-i)-1 -: SIZE];
        end
      end
    end
  end

  // Reading mem here sees the value before any same-edge write (read-first).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else if (|gnt) begin
      rsp_valid <= 1'b1;
      rsp_id    <= gnt_id;
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        rsp_data[SIZE*(BLOCK_SIZE-i)-1 -: SIZE] <=
          mem[IDX_W'(wrap_idx(32'(rd_addr), i, DEPTH))];
      end
    end else if (bus.i_rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_blk_mem_arb.sv
module tb_blk_mem_arb;
  localparam int DEPTH = 1024;
  localparam int SIZE  = 32;
  localparam int BS    = 5;
  localparam int AS    = 24;
  localparam int NRD   = 2;
  localparam int W     = SIZE * BS;

  typedef struct packed {
    logic [W-1:0] data;
    logic         id;
  } rsp_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   rr_next = 0;
  rsp_t exp_q[$];
  logic [SIZE-1:0] model [DEPTH];

  blk_mem_arb_if #(.SIZE(SIZE), .BLOCK_SIZE(BS), .ADDR_SIZE(AS), .NUM_RD(NRD)) bus ();

  blk_mem_arb #(.DEPTH(DEPTH), .SIZE(SIZE), .BLOCK_SIZE(BS),
                .ADDR_SIZE(AS), .NUM_RD(NRD)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] model_blk(input int addr);
    logic [W-1:0] r;
    for (int i = 0; i < BS; i++) r[(BS-i)*SIZE-1 -: SIZE] = model[(addr + i) % DEPTH];
    return r;
  endfunction

  task automatic model_write(input int addr, input logic [W-1:0] data, input int size);
    int n;
    n = (size > BS) ? BS : size;
    for (int i = 0; i < n; i++) model[(addr + i) % DEPTH] = data[(BS-i)*SIZE-1 -: SIZE];
  endtask

  // Drivers: start and end at posedge+1.
  task automatic write_blk(input int addr, input logic [W-1:0] data, input int size);
    bus.i_wr_valid = 1'b1;
    bus.i_wr_addr  = AS'(addr);
    bus.i_wr_data  = data;
    bus.i_wr_size  = 3'(size);
    @(posedge clk);
    model_write(addr, data, size);
    #1;
    bus.i_wr_valid = 1'b0;
  endtask

  task automatic read_blk(input int ch, input int addr);
    bus.i_rd_valid[ch] = 1'b1;
    bus.i_rd_addr[ch*AS +: AS] = AS'(addr);
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (bus.o_rd_ready[ch] === 1'b1) begin
        exp_q.push_back('{data: model_blk(addr), id: 1'(ch)});
        rr_next = (ch + 1) % NRD;
        @(posedge clk); #1;
        bus.i_rd_valid[ch] = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL read_grant_timeout: ch %0d got no grant, want grant within 10 cycles", ch);
    bus.i_rd_valid[ch] = 1'b0;
  endtask

  task automatic test_reset();
    rsp_t e;
    rst = 1'b1;
    bus.i_rd_valid = '1;
    bus.i_rd_addr  = '0;
    bus.i_wr_valid = 1'b1;
    bus.i_wr_addr  = '0;
    bus.i_wr_size  = 3'd5;
    bus.i_wr_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.o_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", bus.o_rsp_valid); end
    checks++; if (bus.o_rd_ready !== 2'b00) begin errors++; $display("FAIL reset_rd_ready: got %b want 00", bus.o_rd_ready); end
    checks++; if (bus.o_wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready: got %b want 0", bus.o_wr_ready); end
    checks++; if (bus.o_rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id: got %b want 0", bus.o_rsp_id); end
    checks++; if (bus.o_rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data: got %h want 0", bus.o_rsp_data); end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.i_wr_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.o_rd_ready !== 2'b01) begin errors++; $display("FAIL first_grant: got %b want 01", bus.o_rd_ready); end
    checks++; if (bus.o_wr_ready !== 1'b1) begin errors++; $display("FAIL wr_ready_after_reset: got %b want 1", bus.o_wr_ready); end
    rr_next = 1;
    @(posedge clk); #1;
    bus.i_rd_valid = '0;
    @(negedge clk);
    checks++; if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_id !== 1'b0) begin
      errors++; $display("FAIL first_rsp: got valid %b id %b want valid 1 id 0", bus.o_rsp_valid, bus.o_rsp_id);
    end
    @(posedge clk); #1;
    e = '0;
  endtask

  task automatic test_fill();
    logic [W-1:0] d;
    for (int k = 0; k < 205; k++) begin
      for (int i = 0; i < BS; i++) d[(BS-i)*SIZE-1 -: SIZE] = $urandom;
      write_blk(5 * k, d, 5);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    rsp_t e;
    write_blk(32'h10, {32'd1, 32'd2, 32'd3, 32'd4, 32'd5}, 5);
    read_blk(0, 32'h10);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (bus.o_rsp_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", bus.o_rsp_valid); end
    checks++; if (bus.o_rsp_data !== {32'd1, 32'd2, 32'd3, 32'd4, 32'd5}) begin
      errors++; $display("FAIL basic_data: got %h want 1..5", bus.o_rsp_data);
    end
    checks++; if (bus.o_rsp_id !== e.id) begin errors++; $display("FAIL basic_id: got %b want %b", bus.o_rsp_id, e.id); end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    rsp_t e;
    write_blk(DEPTH - 2, {32'hA, 32'hB, 32'hC, 32'hD, 32'hE}, 5);
    read_blk(0, DEPTH - 2);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_data !== {32'hA, 32'hB, 32'hC, 32'hD, 32'hE}) begin
      errors++; $display("FAIL wrap_data: got valid %b data %h want A..E", bus.o_rsp_valid, bus.o_rsp_data);
    end
    @(posedge clk); #1;
    read_blk(1, 0);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (bus.o_rsp_data[W-1 -: 3*SIZE] !== {32'hC, 32'hD, 32'hE}) begin
      errors++; $display("FAIL wrap_low_elems: got %h want C,D,E", bus.o_rsp_data[W-1 -: 3*SIZE]);
    end
    checks++; if (bus.o_rsp_data !== e.data || bus.o_rsp_id !== 1'b1) begin
      errors++; $display("FAIL wrap_rsp0: got %h id %b want %h id 1", bus.o_rsp_data, bus.o_rsp_id, e.data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_partial();
    rsp_t e;
    write_blk(32'h20, {5{32'h9}}, 5);
    write_blk(32'h20, {32'h1234_5678, 32'h9ABC_DEF0, 32'h7777_7777, 32'h6666_6666, 32'h5555_5555}, 2);
    read_blk(0, 32'h20);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (bus.o_rsp_data !== {32'h1234_5678, 32'h9ABC_DEF0, 32'h9, 32'h9, 32'h9}) begin
      errors++; $display("FAIL partial_size2: got %h want d0,d1,9,9,9", bus.o_rsp_data);
    end
    @(posedge clk); #1;
    write_blk(32'h20, {5{32'hDEAD_BEEF}}, 0);
    read_blk(1, 32'h20);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (bus.o_rsp_data !== {32'h1234_5678, 32'h9ABC_DEF0, 32'h9, 32'h9, 32'h9}) begin
      errors++; $display("FAIL partial_size0: got %h want d0,d1,9,9,9", bus.o_rsp_data);
    end
    @(posedge clk); #1;
    write_blk(32'h28, {32'h11, 32'h22, 32'h33, 32'h44, 32'h55}, 7);
    read_blk(0, 32'h28);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (bus.o_rsp_data !== {32'h11, 32'h22, 32'h33, 32'h44, 32'h55}) begin
      errors++; $display("FAIL partial_size7: got %h want 11..55", bus.o_rsp_data);
    end
    @(posedge clk); #1;
    read_blk(1, 32'h2D);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (bus.o_rsp_data !== e.data) begin
      errors++; $display("FAIL partial_clamp_beyond: got %h want %h", bus.o_rsp_data, e.data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_read_first();
    rsp_t e;
    logic [W-1:0] nd;
    nd = {32'hF1, 32'hF2, 32'hF3, 32'hF4, 32'hF5};
    bus.i_wr_valid = 1'b1;
    bus.i_wr_addr  = AS'(32'h40);
    bus.i_wr_data  = nd;
    bus.i_wr_size  = 3'd5;
    bus.i_rd_valid = 2'b01;
    bus.i_rd_addr[0 +: AS] = AS'(32'h42);
    @(negedge clk);
    checks++; if (bus.o_rd_ready !== 2'b01 || bus.o_wr_ready !== 1'b1) begin
      errors++; $display("FAIL rf_handshake: got rd_ready %b wr_ready %b want 01 1", bus.o_rd_ready, bus.o_wr_ready);
    end
    exp_q.push_back('{data: model_blk(32'h42), id: 1'b0});
    rr_next = 1;
    @(posedge clk);
    model_write(32'h40, nd, 5);
    #1;
    bus.i_wr_valid = 1'b0;
    bus.i_rd_valid = '0;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_data !== e.data) begin
      errors++; $display("FAIL read_first: got %h want %h", bus.o_rsp_data, e.data);
    end
    @(posedge clk); #1;
    read_blk(1, 32'h40);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (bus.o_rsp_data !== nd) begin errors++; $display("FAIL rf_after_write: got %h want %h", bus.o_rsp_data, nd); end
    @(posedge clk); #1;
  endtask

  task automatic test_rr();
    rsp_t e;
    bus.i_rsp_ready = 1'b1;
    bus.i_rd_addr[0 +: AS]  = AS'(32'h10);
    bus.i_rd_addr[AS +: AS] = AS'(32'h20);
    bus.i_rd_valid = 2'b11;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++; if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_data !== e.data || bus.o_rsp_id !== e.id) begin
          errors++; $display("FAIL rr_rsp: got v%b id %b %h want id %b %h", bus.o_rsp_valid, bus.o_rsp_id, bus.o_rsp_data, e.id, e.data);
        end
      end
      checks++; if (bus.o_rd_ready !== NRD'(1 << rr_next)) begin
        errors++; $display("FAIL rr_grant: got %b want ch %0d", bus.o_rd_ready, rr_next);
      end
      exp_q.push_back('{data: model_blk(rr_next == 0 ? 32'h10 : 32'h20), id: 1'(rr_next)});
      rr_next = (rr_next + 1) % NRD;
      @(posedge clk); #1;
    end
    bus.i_rd_valid = '0;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_data !== e.data || bus.o_rsp_id !== e.id) begin
      errors++; $display("FAIL rr_last_rsp: got id %b %h want id %b %h", bus.o_rsp_id, bus.o_rsp_data, e.id, e.data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    rsp_t e;
    bus.i_rsp_ready = 1'b0;
    bus.i_rd_valid  = 2'b11;
    @(negedge clk);
    checks++; if (bus.o_rd_ready !== NRD'(1 << rr_next)) begin errors++; $display("FAIL bp_grant: got %b want ch %0d", bus.o_rd_ready, rr_next); end
    exp_q.push_back('{data: model_blk(rr_next == 0 ? 32'h10 : 32'h20), id: 1'(rr_next)});
    rr_next = (rr_next + 1) % NRD;
    @(posedge clk); #1;
    repeat (3) begin
      @(negedge clk);
      e = exp_q[0];
      checks++; if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_data !== e.data || bus.o_rsp_id !== e.id) begin
        errors++; $display("FAIL bp_hold: got v%b id %b %h want id %b %h", bus.o_rsp_valid, bus.o_rsp_id, bus.o_rsp_data, e.id, e.data);
      end
      checks++; if (bus.o_rd_ready !== 2'b00) begin errors++; $display("FAIL bp_no_grant: got %b want 00", bus.o_rd_ready); end
      @(posedge clk); #1;
    end
    bus.i_rsp_ready = 1'b1;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_data !== e.data) begin errors++; $display("FAIL bp_release: got %h want %h", bus.o_rsp_data, e.data); end
    checks++; if (bus.o_rd_ready !== NRD'(1 << rr_next)) begin errors++; $display("FAIL bp_resume_grant: got %b want ch %0d", bus.o_rd_ready, rr_next); end
    exp_q.push_back('{data: model_blk(rr_next == 0 ? 32'h10 : 32'h20), id: 1'(rr_next)});
    rr_next = (rr_next + 1) % NRD;
    @(posedge clk); #1;
    bus.i_rd_valid = '0;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_data !== e.data || bus.o_rsp_id !== e.id) begin
      errors++; $display("FAIL bp_second_rsp: got id %b %h want id %b %h", bus.o_rsp_id, bus.o_rsp_data, e.id, e.data);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (bus.o_rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b want 0", bus.o_rsp_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    rsp_t e;
    logic [W-1:0] d;
    logic [NRD-1:0] g;
    logic en;
    int ch, c, wa, ws;
    logic wv;
    for (int n = 0; n < 60; n++) begin
      wv = 1'($urandom_range(0, 1));
      wa = int'($urandom & 32'h00FF_FFFF);
      ws = int'($urandom_range(0, 7));
      for (int i = 0; i < BS; i++) d[(BS-i)*SIZE-1 -: SIZE] = $urandom;
      bus.i_wr_valid = wv;
      bus.i_wr_addr  = AS'(wa);
      bus.i_wr_data  = d;
      bus.i_wr_size  = 3'(ws);
      bus.i_rd_valid = NRD'($urandom_range(0, 3));
      bus.i_rd_addr  = {AS'($urandom), AS'($urandom)};
      bus.i_rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      en = (exp_q.size() == 0) || bus.i_rsp_ready;
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        checks++; if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_data !== e.data || bus.o_rsp_id !== e.id) begin
          errors++; $display("FAIL rnd_rsp: cyc %0d got v%b id %b %h want id %b %h", n, bus.o_rsp_valid, bus.o_rsp_id, bus.o_rsp_data, e.id, e.data);
        end
        if (bus.i_rsp_ready) void'(exp_q.pop_front());
      end else begin
        checks++; if (bus.o_rsp_valid !== 1'b0) begin errors++; $display("FAIL rnd_idle: cyc %0d got %b want 0", n, bus.o_rsp_valid); end
      end
      g = '0; ch = 0;
      if (en) begin
        for (int k = NRD - 1; k >= 0; k--) begin
          c = (rr_next + k) % NRD;
          if (bus.i_rd_valid[c]) begin g = NRD'(1 << c); ch = c; end
        end
      end
      checks++; if (bus.o_rd_ready !== g) begin errors++; $display("FAIL rnd_grant: cyc %0d got %b want %b", n, bus.o_rd_ready, g); end
      if (g != '0) begin
        exp_q.push_back('{data: model_blk(int'(bus.i_rd_addr[ch*AS +: AS])), id: 1'(ch)});
        rr_next = (ch + 1) % NRD;
      end
      @(posedge clk);
      if (wv) model_write(wa, d, ws);
      #1;
    end
    bus.i_wr_valid = 1'b0;
    bus.i_rd_valid = '0;
    bus.i_rsp_ready = 1'b1;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++; if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_data !== e.data || bus.o_rsp_id !== e.id) begin
        errors++; $display("FAIL rnd_drain: got %h want %h", bus.o_rsp_data, e.data);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rst_pending();
    rsp_t e;
    bus.i_rsp_ready = 1'b0;
    read_blk(0, 32'h10);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (bus.o_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_discard: got %b want 0", bus.o_rsp_valid); end
    exp_q.delete();
    rr_next = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.i_rsp_ready = 1'b1;
    bus.i_rd_addr[0 +: AS]  = AS'(32'h10);
    bus.i_rd_addr[AS +: AS] = AS'(32'h40);
    bus.i_rd_valid = 2'b11;
    @(negedge clk);
    checks++; if (bus.o_rd_ready !== 2'b01) begin errors++; $display("FAIL rst_ptr: got %b want 01", bus.o_rd_ready); end
    exp_q.push_back('{data: model_blk(32'h10), id: 1'b0});
    rr_next = 1;
    @(posedge clk); #1;
    bus.i_rd_valid = '0;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_data !== e.data || bus.o_rsp_id !== 1'b0) begin
      errors++; $display("FAIL rst_mem_kept: got %h want %h", bus.o_rsp_data, e.data);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.i_wr_valid  = 1'b0;
    bus.i_wr_addr   = '0;
    bus.i_wr_data   = '0;
    bus.i_wr_size   = '0;
    bus.i_rd_valid  = '0;
    bus.i_rd_addr   = '0;
    bus.i_rsp_ready = 1'b1;
    test_reset();
    test_fill();
    test_basic();
    test_wrap();
    test_partial();
    test_read_first();
    test_rr();
    test_backpressure();
    test_random();
    test_rst_pending();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/blk_mem_arb.md
BLK_MEM_ARB -- requirements
Module: blk_mem_arb

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, number of SIZE-bit elements; power of two.
REQ-002 SHALL have parameter SIZE, default 32, element width in bits.
REQ-003 SHALL have parameter BLOCK_SIZE, default 5, elements per block transfer.
REQ-004 SHALL have parameter ADDR_SIZE, default 24, element address width.
REQ-005 SHALL have parameter NUM_RD, default 2, number of read request channels.
REQ-006 SHALL have port i_clk, input, 1, the single clock; all logic on rising edge.
REQ-007 SHALL have port i_rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port i_wr_valid, input, 1, write request present.
REQ-009 SHALL have port o_wr_ready, output, 1, write accepted this cycle when high with i_wr_valid.
REQ-010 SHALL have port i_wr_addr, input, ADDR_SIZE, first element address of write.
REQ-011 SHALL have port i_wr_data, input, SIZE*BLOCK_SIZE, element 0 in MSBs.
REQ-012 SHALL have port i_wr_size, input, $clog2(BLOCK_SIZE+1), elements to write (0..BLOCK_SIZE).
REQ-013 SHALL have port i_rd_valid, input, NUM_RD, per-channel read request.
REQ-014 SHALL have port o_rd_ready, output, NUM_RD, one-hot grant; request accepted when valid and ready.
REQ-015 SHALL have port i_rd_addr, input, NUM_RD*ADDR_SIZE, channel c address in slice c.
REQ-016 SHALL have port o_rsp_valid, output, 1, read response present.
REQ-017 SHALL have port i_rsp_ready, input, 1, consumer accepts response.
REQ-018 SHALL have port o_rsp_data, output, SIZE*BLOCK_SIZE, element at addr in MSBs, addr+BLOCK_SIZE-1 in LSBs.
REQ-019 SHALL have port o_rsp_id, output, $clog2(NUM_RD) (min 1), channel that issued the response.

Function
REQ-020 Element index SHALL be (addr+i) mod DEPTH; blocks wrap from DEPTH-1 to 0.
REQ-021 o_wr_ready SHALL be constantly 1 outside reset; write commits elements 0..i_wr_size-1 at the accepting edge.
REQ-022 i_wr_size > BLOCK_SIZE SHALL be clamped to BLOCK_SIZE; size 0 SHALL write nothing.
REQ-023 At most one read SHALL be granted per cycle, round-robin: search starts at channel after last granted.
REQ-024 Grant SHALL be issued only if output slot is empty or being drained (o_rsp_valid=0 or i_rsp_ready=1).
REQ-025 Read latency SHALL be 1 cycle: granted request at edge N gives o_rsp_valid=1 with data after edge N.
REQ-026 o_rsp_valid/o_rsp_data/o_rsp_id SHALL hold stable while o_rsp_valid=1 and i_rsp_ready=0.
REQ-027 Same-cycle read and write to overlapping elements SHALL return pre-write data (read-first).
REQ-028 Arbiter pointer SHALL advance only on an accepted grant.
REQ-029 Simultaneous write and read SHALL both complete; no write stalls.

Reset
REQ-030 During i_rst: o_rsp_valid=0, o_rd_ready=0, o_wr_ready=0, o_rsp_id=0, o_rsp_data=0, pointer=channel 0.
REQ-031 Memory contents SHALL NOT be cleared; in-flight response SHALL be discarded.
REQ-032 Requests presented during reset SHALL not be accepted; first grant on first cycle after deassertion.

Structure
REQ-033 Shared package mem_pkg SHALL hold the wrap-index function and response-id width function.
REQ-034 Round-robin grant logic SHALL be sub-module rr_arbiter (parameter N, inputs req/en, output one-hot gnt).

Verification
REQ-035 Write addr 0x10 size 5 data 1..5, then ch0 read 0x10 -> next-cycle rsp_data 1,2,3,4,5, id 0.
REQ-036 Write addr DEPTH-2 size 5 data A..E -> reads at DEPTH-2 return A..E; elements 0..2 hold C,D,E.
REQ-037 Write size 2 over block of 9s at 0x20 -> read returns data0,data1,9,9,9; size 7 writes 5 elements.
REQ-038 Both channels request every cycle, rsp_ready=1 -> grants alternate 0,1,0,1; ids match.
REQ-039 rsp_ready=0 for 3 cycles -> response stable, o_rd_ready all 0; resume on ready.
REQ-040 Assert i_rst with response pending -> o_rsp_valid=0 next edge; earlier written data still readable.
